// File: rtl/guess_judge_n.sv
// guess_judge_n: parametrised guess evaluator for the number-guessing game.
// Sits between the keypad digit registers and the display/score logic.
// Edge-detects confirm, captures the guess, evaluates it one cycle later,
// and produces hints, round progression, per-difficulty miss counts and
// the win/lose lockout.
//
// Ports:
//   clk             system clock
//   restart         asynchronous active-low reset
//   confirm         synchronised confirm button level, active-high
//   keys            player guess, digit i at [i*DIGIT_W +: DIGIT_W], digit 0 LS
//   answer          target value, same packing as keys
//   num_digits      difficulty (active digit count), valid 1..MAX_DIGITS
//   hint            direction to guess next: lower=2'b00, higher=2'b01, none=2'b11
//   round           current round, starts at 1
//   incorrect_guess miss counter of the currently selected difficulty
//   result_valid    one-cycle pulse when an evaluation completes
//   game_won        high in WIN state
//   game_over       high in LOSE state
module guess_judge_n #(
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned DIGIT_W    = 4,
  parameter int unsigned ROUND_W    = 4,
  parameter int unsigned MISS_W     = 3,
  parameter int unsigned MAX_MISSES = 7,
  parameter int unsigned NUM_ROUNDS = 9
) (
  input  logic                              clk,
  input  logic                              restart,
  input  logic                              confirm,
  input  logic [MAX_DIGITS*DIGIT_W-1:0]     keys,
  input  logic [MAX_DIGITS*DIGIT_W-1:0]     answer,
  input  logic [$clog2(MAX_DIGITS+1)-1:0]   num_digits,
  output logic [1:0]                        hint,
  output logic [ROUND_W-1:0]                round,
  output logic [MISS_W-1:0]                 incorrect_guess,
  output logic                              result_valid,
  output logic                              game_won,
  output logic                              game_over
);

  localparam int unsigned ND_W  = $clog2(MAX_DIGITS + 1);
  localparam int unsigned IDX_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
  localparam int unsigned VEC_W = MAX_DIGITS * DIGIT_W;

  typedef enum logic [1:0] {
    S_PLAY,
    S_EVAL,
    S_WIN,
    S_LOSE
  } state_t;

  state_t                 state;
  logic                   confirm_q;
  logic [VEC_W-1:0]       keys_r;
  logic [VEC_W-1:0]       answer_r;
  logic [ND_W-1:0]        nd_r;
  logic [MISS_W-1:0]      miss_cnt [MAX_DIGITS];

  logic                   rise;
  logic                   nd_valid;
  logic [IDX_W-1:0]       cur_idx;
  logic [IDX_W-1:0]       eval_idx;
  logic                   cmp_diff;
  logic                   cmp_gt;
  logic [MISS_W-1:0]      miss_cur;
  logic [MISS_W-1:0]      miss_next;
  logic                   miss_lose;

  assign rise     = confirm & ~confirm_q;
  assign nd_valid = (num_digits != '0) && (32'(num_digits) <= MAX_DIGITS);
  assign cur_idx  = IDX_W'(num_digits - ND_W'(1));
  assign eval_idx = IDX_W'(nd_r - ND_W'(1));

  assign incorrect_guess = nd_valid ? miss_cnt[cur_idx] : '0;

  // Ascending scan: a later (more significant) differing digit overwrites
  // an earlier one, so the final result reflects the most significant diff.
  always_comb begin
    cmp_diff = 1'b0;
    cmp_gt   = 1'b0;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if ((i < 32'(nd_r)) &&
          (keys_r[i*DIGIT_W +: DIGIT_W] != answer_r[i*DIGIT_W +: DIGIT_W])) begin
        cmp_diff = 1'b1;
        cmp_gt   = keys_r[i*DIGIT_W +: DIGIT_W] > answer_r[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

  always_comb begin
    miss_cur  = miss_cnt[eval_idx];
    miss_next = (miss_cur == '1) ? miss_cur : miss_cur + 1'b1;
    miss_lose = 32'(miss_next) >= MAX_MISSES;
  end

  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      state        <= S_PLAY;
      confirm_q    <= 1'b1;
      hint         <= 2'b11;
      round        <= ROUND_W'(1);
      result_valid <= 1'b0;
      game_won     <= 1'b0;
      game_over    <= 1'b0;
      keys_r       <= '0;
      answer_r     <= '0;
      nd_r         <= '0;
      for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
        miss_cnt[i] <= '0;
      end
    end else begin
      confirm_q    <= confirm;
      result_valid <= 1'b0;
      case (state)
        S_PLAY: begin
          if (rise && nd_valid) begin
            keys_r   <= keys;
            answer_r <= answer;
            nd_r     <= num_digits;
            state    <= S_EVAL;
          end
        end
        S_EVAL: begin
          result_valid <= 1'b1;
          if (!cmp_diff) begin
            hint <= 2'b11;
            if (round == ROUND_W'(NUM_ROUNDS)) begin
              state    <= S_WIN;
              game_won <= 1'b1;
            end else begin
              round <= round + 1'b1;
              state <= S_PLAY;
            end
          end else begin
            hint               <= cmp_gt ? 2'b00 : 2'b01;
            miss_cnt[eval_idx] <= miss_next;
            if (miss_lose) begin
              state     <= S_LOSE;
              game_over <= 1'b1;
            end else begin
              state <= S_PLAY;
            end
          end
        end
        S_WIN, S_LOSE: begin
          state <= state;
        end
        default: state <= S_PLAY;
      endcase
    end
  end

endmodule

// File: tb/tb_guess_judge_n.sv
// Testbench for guess_judge_n: directed scenarios plus randomized presses,
// all checked against a value-level model of the game rules.
module tb_guess_judge_n;

  localparam int unsigned MD  = 4;
  localparam int unsigned DW  = 4;
  localparam int unsigned RW  = 4;
  localparam int unsigned MW  = 3;
  localparam int unsigned MM  = 7;
  localparam int unsigned NR  = 9;
  localparam int unsigned NDW = $clog2(MD + 1);

  logic              clk = 1'b0;
  logic              restart;
  logic              confirm;
  logic [MD*DW-1:0]  keys;
  logic [MD*DW-1:0]  answer;
  logic [NDW-1:0]    num_digits;
  logic [1:0]        hint;
  logic [RW-1:0]     round;
  logic [MW-1:0]     incorrect_guess;
  logic              result_valid;
  logic              game_won;
  logic              game_over;

  guess_judge_n #(
    .MAX_DIGITS(MD),
    .DIGIT_W(DW),
    .ROUND_W(RW),
    .MISS_W(MW),
    .MAX_MISSES(MM),
    .NUM_ROUNDS(NR)
  ) dut (
    .clk,
    .restart,
    .confirm,
    .keys,
    .answer,
    .num_digits,
    .hint,
    .round,
    .incorrect_guess,
    .result_valid,
    .game_won,
    .game_over
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: game values held as plain integers.
  int unsigned m_round;
  int unsigned m_miss [MD];
  bit          m_won;
  bit          m_over;
  logic [1:0]  m_hint;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_round = 1;
    for (int i = 0; i < MD; i++) m_miss[i] = 0;
    m_won  = 1'b0;
    m_over = 1'b0;
    m_hint = 2'b11;
  endtask

  function automatic int unsigned exp_ig(input int unsigned nd);
    if (nd >= 1 && nd <= MD) return m_miss[nd-1];
    return 0;
  endfunction

  // A guess is a number made of its active digits; compare the masked values.
  task automatic model_eval(input logic [MD*DW-1:0] k, input logic [MD*DW-1:0] a,
                            input int unsigned nd, output bit acc);
    longint unsigned mask, kv, av;
    acc = 1'b0;
    if (m_won || m_over || nd < 1 || nd > MD) return;
    acc  = 1'b1;
    mask = (64'd1 << (nd * DW)) - 64'd1;
    kv   = 64'(k) & mask;
    av   = 64'(a) & mask;
    if (kv == av) begin
      m_hint = 2'b11;
      if (m_round == NR) m_won = 1'b1;
      else m_round++;
    end else begin
      m_hint = (kv > av) ? 2'b00 : 2'b01;
      if (m_miss[nd-1] < (1 << MW) - 1) m_miss[nd-1]++;
      if (m_miss[nd-1] >= MM) m_over = 1'b1;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_hint"},  hint, m_hint);
    check({tag, "_round"}, round, m_round);
    check({tag, "_ig"},    incorrect_guess, exp_ig(num_digits));
    check({tag, "_won"},   game_won, m_won);
    check({tag, "_over"},  game_over, m_over);
  endtask

  task automatic do_reset();
    @(negedge clk);
    restart = 1'b0;
    #1;
    model_reset();
    check_outputs("rst");
    check("rst_rv", result_valid, 0);
    @(negedge clk);
    restart = 1'b1;
  endtask

  task automatic press(input logic [MD*DW-1:0] k, input logic [MD*DW-1:0] a,
                       input logic [NDW-1:0] nd, input int unsigned hold, input bit scramble);
    bit acc;
    @(negedge clk);
    keys = k; answer = a; num_digits = nd; confirm = 1'b1;
    @(posedge clk); #1;
    check("rv_capture", result_valid, 0);
    if (scramble) begin
      keys       = MD*DW'($urandom);
      answer     = MD*DW'($urandom);
      num_digits = NDW'($urandom_range(0, (1 << NDW) - 1));
    end
    @(posedge clk); #1;
    model_eval(k, a, nd, acc);
    check("rv_eval", result_valid, acc);
    check_outputs("eval");
    for (int unsigned c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      check("rv_hold", result_valid, 0);
    end
    @(negedge clk);
    confirm = 1'b0;
    @(posedge clk); #1;
    check("rv_idle", result_valid, 0);
    check_outputs("idle");
  endtask

  task automatic abort_press(input logic [MD*DW-1:0] k, input logic [MD*DW-1:0] a,
                             input logic [NDW-1:0] nd);
    @(negedge clk);
    keys = k; answer = a; num_digits = nd; confirm = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    #1;
    model_reset();
    check_outputs("abort");
    @(posedge clk); #1;
    check("abort_rv", result_valid, 0);
    @(negedge clk);
    restart = 1'b1;
    @(posedge clk); #1;
    check("abort_held_rv", result_valid, 0);
    check_outputs("abort_held");
    @(negedge clk);
    confirm = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MD*DW-1:0] rk, ra;
    logic [NDW-1:0]   rn;

    // Reset with confirm held high: releasing reset must not produce a rise.
    restart = 1'b0; confirm = 1'b1;
    keys = '0; answer = '0; num_digits = NDW'(1);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("por");
    @(negedge clk);
    restart = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("held_rv", result_valid, 0);
    end
    check_outputs("held");
    @(negedge clk);
    confirm = 1'b0;
    @(posedge clk);

    // Basic one-digit miss.
    press(16'h0007, 16'h0005, NDW'(1), 0, 1'b0);
    check("t1_hint", hint, 2'b00);
    check("t1_ig", incorrect_guess, 1);

    // Three digits, decided by digit 1; then a correct guess.
    press(16'h0469, 16'h0472, NDW'(3), 0, 1'b0);
    check("t2_hint", hint, 2'b01);
    press(16'h9472, 16'h1472, NDW'(3), 0, 1'b1);
    check("t2c_hint", hint, 2'b11);
    check("t2c_round", round, 2);
    num_digits = NDW'(3); #1;
    check("t2c_ig", incorrect_guess, 1);

    // Long hold counts once.
    press(16'h0111, 16'h0222, NDW'(3), 10, 1'b0);
    check("hold_ig", incorrect_guess, 2);

    // Invalid difficulty is ignored.
    press(16'h0001, 16'h0002, NDW'(0), 0, 1'b0);
    check("nd0_ig", incorrect_guess, 0);
    press(16'h0001, 16'h0002, NDW'(5), 0, 1'b0);

    // Per-difficulty counters retained across difficulty changes.
    do_reset();
    press(16'h0001, 16'h0002, NDW'(1), 0, 1'b0);
    press(16'h0003, 16'h0002, NDW'(1), 0, 1'b0);
    press(16'h0010, 16'h0020, NDW'(2), 0, 1'b0);
    num_digits = NDW'(1); #1;
    check("pd_ig1", incorrect_guess, 2);
    num_digits = NDW'(2); #1;
    check("pd_ig2", incorrect_guess, 1);
    num_digits = NDW'(4); #1;
    check("pd_ig4", incorrect_guess, 0);

    // Win after NUM_ROUNDS correct guesses; further rises ignored.
    do_reset();
    for (int i = 0; i < NR; i++) press(16'h5673, 16'h1233, NDW'(1), 0, 1'b0);
    check("win_flag", game_won, 1);
    check("win_round", round, NR);
    press(16'h0003, 16'h0004, NDW'(1), 0, 1'b0);
    check("win_locked_ig", incorrect_guess, 0);

    // Lose after MAX_MISSES misses; further rises ignored.
    do_reset();
    for (int i = 0; i < MM; i++) press(16'h0000, 16'h0033, NDW'(2), 0, 1'b0);
    check("lose_ig", incorrect_guess, MM);
    check("lose_flag", game_over, 1);
    press(16'h0033, 16'h0033, NDW'(2), 0, 1'b0);
    check("lose_locked_round", round, 1);
    do_reset();

    // Reset arriving during evaluation.
    press(16'h0001, 16'h0002, NDW'(1), 0, 1'b0);
    abort_press(16'h0001, 16'h0009, NDW'(1));

    // Randomized play.
    for (int n = 0; n < 400; n++) begin
      if ((m_won || m_over) && $urandom_range(0, 3) == 0) do_reset();
      rn = NDW'($urandom_range(0, (1 << NDW) - 1));
      ra = MD*DW'($urandom);
      rk = MD*DW'($urandom);
      case ($urandom_range(0, 3))
        0: rk = ra;
        1: rk = ra ^ (MD*DW'(1) << (4 * $urandom_range(0, MD - 1)));
        default: ;
      endcase
      if ($urandom_range(0, 30) == 0) abort_press(rk, ra, rn);
      else press(rk, ra, rn, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
